// File: rtl/fclass_s_if.sv
// rtl/fclass_s_if.sv - operand/result bundle for the binary32 FCLASS.S unit
interface fclass_s_if;
  logic        in_valid;
  logic [31:0] rs1;
  logic        out_valid;
  logic [9:0]  rd;

  modport master (
    output in_valid,
    output rs1,
    input  out_valid,
    input  rd
  );

  modport slave (
    input  in_valid,
    input  rs1,
    output out_valid,
    output rd
  );
endinterface

// File: rtl/fclass_s.sv
// rtl/fclass_s.sv - binary32 FCLASS.S: one-hot class mask of rs1, one cycle latency
module fclass_s (
  input logic       clk,
  input logic       rst,
  fclass_s_if.slave bus
);
  logic [7:0]  exp_w;
  logic [22:0] frac_w;
  logic        neg_w;
  logic        pos_w;
  logic        exp_max_w;
  logic        exp_min_w;
  logic        frac_nz_w;
  logic        is_nan_w;
  logic        is_inf_w;
  logic        is_zero_w;
  logic        is_sub_w;
  logic        is_norm_w;
  logic [9:0]  class_w;

  logic [9:0]  rd_d;
  logic [9:0]  rd_q;
  logic        out_valid_d;
  logic        out_valid_q;

  assign exp_w  = bus.rs1[30:23];
  assign frac_w = bus.rs1[22:0];
  assign neg_w  = bus.rs1[31];
  assign pos_w  = ~bus.rs1[31];

  assign exp_max_w = &exp_w;
  assign exp_min_w = ~|exp_w;
  assign frac_nz_w = |frac_w;

  assign is_nan_w  = exp_max_w & frac_nz_w;
  assign is_inf_w  = exp_max_w & ~frac_nz_w;
  assign is_zero_w = exp_min_w & ~frac_nz_w;
  assign is_sub_w  = exp_min_w & frac_nz_w;
  assign is_norm_w = ~exp_max_w & ~exp_min_w;

  // NaN bits deliberately ignore the sign; frac[22] is the quiet bit.
  assign class_w = {
    is_nan_w & frac_w[22],
    is_nan_w & ~frac_w[22],
    pos_w & is_inf_w,
    pos_w & is_norm_w,
    pos_w & is_sub_w,
    pos_w & is_zero_w,
    neg_w & is_zero_w,
    neg_w & is_sub_w,
    neg_w & is_norm_w,
    neg_w & is_inf_w
  };

  // Idle cycles keep rd, so an unknown rs1 without in_valid never lands in it.
  always_comb begin
    rd_d        = rd_q;
    out_valid_d = 1'b0;
    if (bus.in_valid) begin
      rd_d        = class_w;
      out_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q        <= 10'b0;
      out_valid_q <= 1'b0;
    end else begin
      rd_q        <= rd_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.rd        = rd_q;
  assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_fclass_s.sv
// tb/tb_fclass_s.sv - scoreboard bench for fclass_s
module tb_fclass_s;
  logic clk;
  logic rst;
  fclass_s_if bus ();

  fclass_s dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int pops  = 0;
  logic [9:0] exp_q[$];
  logic [9:0] last_exp;

  function automatic logic [9:0] ref_class(input logic [31:0] x);
    logic [9:0] r;
    r = 10'b0;
    if (x[30:23] == 8'hFF) begin
      if (x[22:0] == 23'd0) r = x[31] ? 10'd1 : 10'd128;
      else if (x[22])       r = 10'd512;
      else                  r = 10'd256;
    end else if (x[30:23] == 8'h00) begin
      if (x[22:0] == 23'd0) r = x[31] ? 10'd8 : 10'd16;
      else                  r = x[31] ? 10'd4 : 10'd32;
    end else begin
      r = x[31] ? 10'd2 : 10'd64;
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && bus.out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_out_valid: got rd=%b, expected no result", bus.rd);
      end else begin
        logic [9:0] e;
        e = exp_q.pop_front();
        pops++;
        tests++;
        if (bus.rd !== e) begin
          fails++;
          $display("FAIL rd_result: got %b, expected %b", bus.rd, e);
        end
        tests++;
        if (!$onehot(bus.rd)) begin
          fails++;
          $display("FAIL rd_onehot: got %b, expected one-hot", bus.rd);
        end
      end
    end
  end

  task automatic send(input logic [31:0] v, input logic [9:0] e);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b1;
    bus.rs1      = v;
    exp_q.push_back(e);
    last_exp = e;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
    end
  endtask

  initial begin
    int p0;
    logic [31:0] r;
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.rs1      = 32'h0;
    #1;
    check("reset_rd", {22'b0, bus.rd}, 32'h0);
    check("reset_out_valid", {31'b0, bus.out_valid}, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    send(32'h7FC00001, 10'b1000000000);
    send(32'h7F800001, 10'b0100000000);
    send(32'hFFC00000, 10'b1000000000);
    send(32'h7F800000, 10'b0010000000);
    send(32'hFF800000, 10'b0000000001);
    send(32'h00000000, 10'b0000010000);
    send(32'h80000000, 10'b0000001000);
    send(32'h00000001, 10'b0000100000);
    send(32'h80000001, 10'b0000000100);
    send(32'h007FFFFF, 10'b0000100000);
    send(32'h3F800000, 10'b0001000000);
    send(32'hBF800000, 10'b0000000010);
    send(32'h00800000, 10'b0001000000);
    send(32'hFF7FFFFF, 10'b0000000010);
    idle(3);

    // three back-to-back, then idle: exactly three results, rd holds the last
    p0 = pops;
    send(32'h3F800000, 10'b0001000000);
    send(32'h80000001, 10'b0000000100);
    send(32'h7F800001, 10'b0100000000);
    idle(1);
    bus.rs1 = 32'hxxxxxxxx;
    idle(4);
    check("burst_count", pops - p0, 32'd3);
    check("burst_hold_rd", {22'b0, bus.rd}, {22'b0, last_exp});
    check("burst_out_valid_low", {31'b0, bus.out_valid}, 32'h0);

    // asynchronous reset while a result is being presented
    send(32'hBF800000, 10'b0000000010);
    @(posedge clk);
    #2;
    check("pre_reset_out_valid", {31'b0, bus.out_valid}, 32'h1);
    rst = 1'b1;
    #1;
    check("async_reset_rd", {22'b0, bus.rd}, 32'h0);
    check("async_reset_out_valid", {31'b0, bus.out_valid}, 32'h0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    check("held_reset_rd", {22'b0, bus.rd}, 32'h0);
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("post_reset_idle_rd", {22'b0, bus.rd}, 32'h0);
    check("post_reset_idle_out_valid", {31'b0, bus.out_valid}, 32'h0);
    send(32'h7F800000, 10'b0010000000);
    idle(2);

    for (int i = 0; i < 10000; i++) begin
      r = $urandom;
      case (i % 4)
        0: r[30:23] = 8'hFF;
        1: r[30:23] = 8'h00;
        default: ;
      endcase
      if (i % 16 == 3) r[22:0] = 23'd0;
      send(r, ref_class(r));
    end
    idle(2);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    check("scoreboard_drained", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
